// File: rtl/sram_d_arbiter.sv
// Two-master OBI arbiter feeding the SRAM wrapper data port. Master 0 is the
// core data port, master 1 the SPI cache fill/writeback engine. An in-order ID
// FIFO routes each response back to the master that issued the request.
module sram_d_arbiter #(
   parameter int MAX_OUTSTANDING = 2,  // ID FIFO depth, 1..8
   parameter int FIXED_PRIO      = 0   // 0 = round-robin, 1 = master 0 wins conflicts
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // master 0: core data port
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   // master 1: SPI fill engine
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   // slave: SRAM wrapper sram_d
   output logic        s_req_o,
   input  logic        s_gnt_i,
   output logic [31:0] s_addr_o,
   output logic        s_we_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_rvalid_i,
   input  logic [31:0] s_rdata_i,
   output logic        protocol_err_o
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

   logic [MAX_OUTSTANDING-1:0] id_q, id_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       last_winner_q, last_winner_d;
   logic                       ignore_rsp_q;
   logic                       protocol_err_q, protocol_err_d;

   logic win_id;
   logic fifo_full, fifo_empty;
   logic accept, pop, rsp_valid, head_id;

   // Pick the winner: lone requester wins; on conflict use fixed priority or
   // hand the slot to the master that did not win last.
   always_comb begin
      win_id = 1'b0;
      if (m0_req_i && m1_req_i) begin
         win_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_winner_q;
      end else if (m1_req_i) begin
         win_id = 1'b1;
      end
   end

   // Request mux, grant split and response routing. Full FIFO blocks new
   // grants regardless of a same-cycle pop, so rvalid never reaches gnt.
   always_comb begin
      fifo_full  = (count_q == CNT_FULL);
      fifo_empty = (count_q == '0);
      s_req_o    = (m0_req_i | m1_req_i) & ~fifo_full;
      accept     = s_req_o & s_gnt_i;
      m0_gnt_o   = accept & ~win_id;
      m1_gnt_o   = accept & win_id;
      s_addr_o   = win_id ? m1_addr_i  : m0_addr_i;
      s_we_o     = win_id ? m1_we_i    : m0_we_i;
      s_be_o     = win_id ? m1_be_i    : m0_be_i;
      s_wdata_o  = win_id ? m1_wdata_i : m0_wdata_i;

      // responses in the first cycle after reset belong to flushed requests
      rsp_valid   = s_rvalid_i & ~ignore_rsp_q;
      pop         = rsp_valid & ~fifo_empty;
      head_id     = id_q[rd_ptr_q];
      m0_rvalid_o = pop & ~head_id;
      m1_rvalid_o = pop & head_id;
      m0_rdata_o  = s_rdata_i;
      m1_rdata_o  = s_rdata_i;
      protocol_err_o = protocol_err_q;
   end

   // Next-state for the ID FIFO, arbitration history and error flag.
   always_comb begin
      id_d           = id_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      last_winner_d  = last_winner_q;
      protocol_err_d = protocol_err_q | (rsp_valid & fifo_empty);
      if (accept) begin
         id_d[wr_ptr_q] = win_id;
         wr_ptr_d       = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         last_winner_d  = win_id;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state with synchronous reset; reset flushes in-flight IDs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         last_winner_q  <= 1'b1;
         ignore_rsp_q   <= 1'b1;
         protocol_err_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         last_winner_q  <= last_winner_d;
         ignore_rsp_q   <= 1'b0;
         protocol_err_q <= protocol_err_d;
      end
   end

   // ID storage is only read behind a non-zero count, so it needs no reset.
   always_ff @(posedge clk_i) begin
      id_q <= id_d;
   end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed bench for sram_d_arbiter: a round-robin and a fixed-priority
// instance share all inputs; expected values are hand-computed per step.
module tb_sram_d_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic        s_gnt, s_rvalid;
   logic [31:0] s_rdata;

   logic        rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid, rr_s_req, rr_s_we, rr_err;
   logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
   logic [3:0]  rr_s_be;
   logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid, fp_s_req, fp_s_we, fp_err;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
   logic [3:0]  fp_s_be;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sram_d_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(0)) dut_rr (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_gnt_o(rr_m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
      .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(rr_m0_rvalid), .m0_rdata_o(rr_m0_rdata),
      .m1_req_i(m1_req), .m1_gnt_o(rr_m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
      .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(rr_m1_rvalid), .m1_rdata_o(rr_m1_rdata),
      .s_req_o(rr_s_req), .s_gnt_i(s_gnt), .s_addr_o(rr_s_addr), .s_we_o(rr_s_we),
      .s_be_o(rr_s_be), .s_wdata_o(rr_s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .protocol_err_o(rr_err)
   );

   sram_d_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1)) dut_fp (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_gnt_o(fp_m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
      .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
      .m1_req_i(m1_req), .m1_gnt_o(fp_m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
      .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
      .s_req_o(fp_s_req), .s_gnt_i(s_gnt), .s_addr_o(fp_s_addr), .s_we_o(fp_s_we),
      .s_be_o(fp_s_be), .s_wdata_o(fp_s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .protocol_err_o(fp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();  // let the post-reset ignore cycle pass
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = 4'hF;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = 4'hF;
      s_gnt = 0; s_rvalid = 0; s_rdata = '0;
      cyc();
      cyc();
      // reset state
      check("rst_m0_gnt", rr_m0_gnt, 0);
      check("rst_m1_gnt", rr_m1_gnt, 0);
      check("rst_m0_rvalid", rr_m0_rvalid, 0);
      check("rst_m1_rvalid", rr_m1_rvalid, 0);
      check("rst_err", rr_err, 0);
      rst = 1'b0;
      cyc();

      // single m0 read
      m0_req = 1; m0_addr = 32'h8000_0010; s_gnt = 1;
      settle();
      check("t1_s_req", rr_s_req, 1);
      check("t1_m0_gnt", rr_m0_gnt, 1);
      check("t1_m1_gnt", rr_m1_gnt, 0);
      check("t1_s_addr", rr_s_addr, 32'h8000_0010);
      cyc();
      m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h1234_5678;
      settle();
      check("t1_m0_rvalid", rr_m0_rvalid, 1);
      check("t1_m0_rdata", rr_m0_rdata, 32'h1234_5678);
      check("t1_m1_rvalid", rr_m1_rvalid, 0);
      cyc();
      s_rvalid = 0;

      // both masters continuously for 4 cycles
      do_reset();
      m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200;
      m0_we = 0; m1_we = 1; m1_wdata = 32'hCAFE_0001; s_gnt = 1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            m0_req = 0; m1_req = 0; s_gnt = 0;
         end
         if (k >= 1) begin
            s_rvalid = 1; s_rdata = 32'hA000_0000 + k;
         end
         settle();
         if (k < 4) begin
            check($sformatf("rr_m0_gnt_%0d", k), rr_m0_gnt, (k % 2 == 0));
            check($sformatf("rr_m1_gnt_%0d", k), rr_m1_gnt, (k % 2 == 1));
            check($sformatf("rr_s_addr_%0d", k), rr_s_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            check($sformatf("rr_s_we_%0d", k), rr_s_we, (k % 2 == 1));
            check($sformatf("fp_m0_gnt_%0d", k), fp_m0_gnt, 1);
            check($sformatf("fp_m1_gnt_%0d", k), fp_m1_gnt, 0);
         end
         if (k >= 1) begin
            check($sformatf("rr_m0_rvalid_%0d", k), rr_m0_rvalid, ((k - 1) % 2 == 0));
            check($sformatf("rr_m1_rvalid_%0d", k), rr_m1_rvalid, ((k - 1) % 2 == 1));
            check($sformatf("rr_m1_rdata_%0d", k), rr_m1_rdata, 32'hA000_0000 + k);
            check($sformatf("fp_m0_rvalid_%0d", k), fp_m0_rvalid, 1);
            check($sformatf("fp_m1_rvalid_%0d", k), fp_m1_rvalid, 0);
         end
         cyc();
      end
      s_rvalid = 0;

      // FIFO full backpressure
      do_reset();
      m0_req = 1; s_gnt = 1;
      settle(); check("full_gnt0", rr_m0_gnt, 1);
      cyc();
      settle(); check("full_gnt1", rr_m0_gnt, 1);
      cyc();
      settle();
      check("full_s_req", rr_s_req, 0);
      check("full_m0_gnt", rr_m0_gnt, 0);
      check("full_m1_gnt", rr_m1_gnt, 0);
      cyc();
      s_rvalid = 1; s_rdata = 32'h0000_00F1;
      settle();
      check("full_pop_gnt", rr_m0_gnt, 0);
      check("full_pop_rvalid", rr_m0_rvalid, 1);
      cyc();
      s_rvalid = 0;
      settle();
      check("full_regrant", rr_m0_gnt, 1);
      cyc();
      m0_req = 0; s_gnt = 0; s_rvalid = 1;
      settle(); check("drain_rv0", rr_m0_rvalid, 1);
      cyc();
      settle(); check("drain_rv1", rr_m0_rvalid, 1);
      cyc();

      // response with empty FIFO
      settle();
      check("err_m0_rvalid", rr_m0_rvalid, 0);
      check("err_m1_rvalid", rr_m1_rvalid, 0);
      check("err_before", rr_err, 0);
      cyc();
      s_rvalid = 0;
      settle(); check("err_set", rr_err, 1);
      cyc();
      cyc();
      check("err_sticky", rr_err, 1);

      // reset with two outstanding, response right after release
      m0_req = 1; s_gnt = 1;
      cyc();
      cyc();
      m0_req = 0; s_gnt = 0;
      rst = 1;
      cyc();
      rst = 0;
      s_rvalid = 1;
      settle();
      check("mid_rst_err", rr_err, 0);
      check("mid_rst_m0_rv", rr_m0_rvalid, 0);
      check("mid_rst_m1_rv", rr_m1_rvalid, 0);
      cyc();
      s_rvalid = 0;
      settle(); check("mid_rst_err_after", rr_err, 0);
      // empty FIFO: exactly two accepts fit before backpressure
      m0_req = 1; s_gnt = 1;
      settle(); check("mid_rst_gnt0", rr_m0_gnt, 1);
      cyc();
      settle(); check("mid_rst_gnt1", rr_m0_gnt, 1);
      cyc();
      settle(); check("mid_rst_gnt2", rr_m0_gnt, 0);
      m0_req = 0; s_gnt = 0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
